redun_carry_resolve: RTL and testbench

Multi-cycle carry-propagation stage that sits directly downstream of the redundant Montgomery squaring core. It converts a `redun0_t` result (NUM_WRDS words of WRD_BITS+1 bits) into a canonical `fe_t` by resolving carries a few words per cycle. It reports any carry out of the top word. The block feeds the MSU readback path, so the multiplier never needs a wide single-cycle adder.

---
 rtl/redun_mont_pkg.sv | 20 ++
 rtl/redun_carry_slice.sv | 29 ++
 rtl/redun_carry_resolve.sv | 119 +++++++++++
 tb/tb_redun_carry_resolve.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/redun_mont_pkg.sv
// Shared types for the redundant Montgomery datapath.
// Word i of a redundant value is weighted 2^(16*i).
package redun_mont_pkg;

  localparam int WRD_BITS = 16;
  localparam int NUM_WRDS = 65;
  localparam int FE_BITS  = NUM_WRDS * WRD_BITS;
  localparam int RESOLVE_WRDS_PER_CYC = 5;

  typedef logic [NUM_WRDS-1:0][WRD_BITS:0]   redun0_t;
  typedef logic [NUM_WRDS-1:0][WRD_BITS-1:0] fe_t;
  typedef logic [1:0]                        carry_t;

  typedef enum logic [1:0] {
    RCR_IDLE,
    RCR_RESOLVE,
    RCR_OUT
  } rcr_state_e;

endpackage

// File: rtl/redun_carry_slice.sv
// Ripple-resolves a group of redundant words into canonical words.
// Incoming carry never exceeds 2, so a 2-bit carry suffices.
module redun_carry_slice
  import redun_mont_pkg::*;
#(
  parameter int N = RESOLVE_WRDS_PER_CYC
) (
  input  logic [N*(WRD_BITS+1)-1:0] i_wrds,
  input  logic [1:0]                i_carry,
  output logic [N*WRD_BITS-1:0]     o_wrds,
  output logic [1:0]                o_carry
);

  always_comb begin
    carry_t              c;
    logic [WRD_BITS+1:0] sum;
    c      = i_carry;
    sum    = '0;
    o_wrds = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, i_wrds[i*(WRD_BITS+1) +: WRD_BITS+1]}
          + {{WRD_BITS{1'b0}}, c};
      o_wrds[i*WRD_BITS +: WRD_BITS] = sum[WRD_BITS-1:0];
      c = sum[WRD_BITS+1:WRD_BITS];
    end
    o_carry = c;
  end

endmodule

// File: rtl/redun_carry_resolve.sv
// Multi-cycle carry resolution of a redundant value into fe_t,
// a few words per clock, flagging any carry out of the top word.
module redun_carry_resolve
  import redun_mont_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_rst_n,
  input  redun0_t i_dat,
  input  logic    i_val,
  output logic    o_rdy,
  output fe_t     o_dat,
  output logic    o_ovf,
  output logic    o_val,
  input  logic    i_rdy
);

  localparam int W      = RESOLVE_WRDS_PER_CYC;
  localparam int NCYC   = NUM_WRDS / W;
  localparam int CNT_W  = $clog2(NCYC);
  localparam int IN_W   = NUM_WRDS * (WRD_BITS + 1);
  localparam int SL_IN  = W * (WRD_BITS + 1);
  localparam int SL_OUT = W * WRD_BITS;

  rcr_state_e state_q, state_d;
  logic [IN_W-1:0]    dat_q, dat_d;
  logic [FE_BITS-1:0] res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  carry_t             carry_q, carry_d;
  logic ovf_q, ovf_d;
  logic rdy_q, rdy_d;
  logic val_q, val_d;

  logic [10:0]       in_lsb;
  logic [10:0]       out_lsb;
  logic [SL_IN-1:0]  sl_in;
  logic [SL_OUT-1:0] sl_out;
  carry_t            sl_carry;
  logic              accept;
  logic              last;

  assign in_lsb  = 11'(cnt_q) * 11'(SL_IN);
  assign out_lsb = 11'(cnt_q) * 11'(SL_OUT);
  assign sl_in   = dat_q[in_lsb +: SL_IN];
  assign accept  = (state_q == RCR_IDLE) && i_val && rdy_q;
  assign last    = (cnt_q == CNT_W'(NCYC - 1));

  redun_carry_slice #(.N(W)) u_slice (
    .i_wrds  (sl_in),
    .i_carry (carry_q),
    .o_wrds  (sl_out),
    .o_carry (sl_carry)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RCR_IDLE;
      dat_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      rdy_q   <= 1'b0;
      val_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      rdy_q   <= rdy_d;
      val_q   <= val_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RCR_IDLE:    if (accept) state_d = RCR_RESOLVE;
      RCR_RESOLVE: if (last) state_d = RCR_OUT;
      RCR_OUT:     if (val_q && i_rdy) state_d = RCR_IDLE;
      default:     state_d = RCR_IDLE;
    endcase
  end

  always_comb begin
    dat_d   = dat_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    unique case (1'b1)
      accept: begin
        dat_d   = i_dat;
        cnt_d   = '0;
        carry_d = '0;
      end
      (state_q == RCR_RESOLVE): begin
        res_d[out_lsb +: SL_OUT] = sl_out;
        carry_d = sl_carry;
        cnt_d   = cnt_q + 1'b1;
        if (last) ovf_d = (sl_carry != '0);
      end
      default: ;
    endcase
  end

  // Handshake flags are decoded from the next state so they stay registered.
  always_comb begin
    rdy_d = (state_d == RCR_IDLE);
    val_d = (state_d == RCR_OUT);
  end

  assign o_rdy = rdy_q;
  assign o_val = val_q;
  assign o_dat = res_q;
  assign o_ovf = ovf_q;

endmodule

// File: tb/tb_redun_carry_resolve.sv
// Directed and random checks of redun_carry_resolve against an
// exact integer model of the redundant value.
module tb_redun_carry_resolve;
  import redun_mont_pkg::*;

  logic    clk;
  logic    i_rst_n;
  redun0_t i_dat;
  logic    i_val;
  logic    o_rdy;
  fe_t     o_dat;
  logic    o_ovf;
  logic    o_val;
  logic    i_rdy;

  int n_asrt;
  int n_fail;

  redun_carry_resolve dut (
    .i_clk   (clk),
    .i_rst_n (i_rst_n),
    .i_dat   (i_dat),
    .i_val   (i_val),
    .o_rdy   (o_rdy),
    .o_dat   (o_dat),
    .o_ovf   (o_ovf),
    .o_val   (o_val),
    .i_rdy   (i_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    redun0_t din;
    fe_t     dat;
    logic    ovf;
    int      stall;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input bit ok, input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_asrt++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_dat(input string nm, input fe_t act,
                         input fe_t exp);
    int idx;
    n_asrt++;
    if (act !== exp) begin
      n_fail++;
      idx = 0;
      for (int i = NUM_WRDS - 1; i >= 0; i--)
        if (act[i] !== exp[i]) idx = i;
      $display("FAIL %s: word %0d got %h expected %h",
               nm, idx, act[idx], exp[idx]);
    end
  endtask

  function automatic logic [1105:0] from_redun(input redun0_t d);
    logic [1105:0] a;
    a = '0;
    for (int i = 0; i < NUM_WRDS; i++)
      a = a + ({1089'b0, d[i]} << (16 * i));
    return a;
  endfunction

  task automatic xfer(input redun0_t d, input int stall,
                      output fe_t dat, output logic ovf,
                      output int lat);
    int n;
    n = 0;
    while (!o_rdy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(o_rdy === 1'b1, "rdy_wait", 64'(o_rdy), 64'd1);
    i_dat = d;
    i_val = 1'b1;
    @(negedge clk);
    i_val = 1'b0;
    i_dat = '0;
    lat = 0;
    while (!o_val && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    dat = o_dat;
    ovf = o_ovf;
    if (o_val !== 1'b1) begin
      chk(1'b0, "oval_timeout", 64'(lat), 64'd13);
      return;
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk(o_val === 1'b1 && o_rdy === 1'b0 &&
          o_dat === dat && o_ovf === ovf, "hold",
          {61'b0, o_val, o_rdy, o_ovf}, {61'b0, 2'b10, ovf});
    end
    i_rdy = 1'b1;
    @(negedge clk);
    i_rdy = 1'b0;
    chk(o_rdy === 1'b1 && o_val === 1'b0, "post_hs",
        {62'b0, o_rdy, o_val}, 64'b10);
  endtask

  initial begin
    fe_t           gdat;
    logic          govf;
    int            lat;
    redun0_t       d;
    logic [1105:0] v;

    n_asrt  = 0;
    n_fail  = 0;
    i_rst_n = 1'b0;
    i_dat   = '0;
    i_val   = 1'b0;
    i_rdy   = 1'b0;

    for (int k = 0; k < 6; k++) begin
      tbl[k].din   = '0;
      tbl[k].dat   = '0;
      tbl[k].ovf   = 1'b0;
      tbl[k].stall = 0;
    end
    // all zero: tbl[0] stays zero
    for (int i = 0; i < NUM_WRDS; i++) begin
      tbl[1].din[i] = 17'h0FFFF;
      tbl[1].dat[i] = 16'hFFFF;
      tbl[2].din[i] = 17'h1FFFF;
      tbl[2].dat[i] = (i == 0) ? 16'hFFFF :
                      (i == 1) ? 16'h0000 : 16'h0001;
      tbl[3].din[i] = 17'h10000;
      tbl[3].dat[i] = (i == 0) ? 16'h0000 : 16'h0001;
      tbl[4].din[i] = (i == 0) ? 17'h10000 : 17'h0FFFF;
    end
    tbl[2].ovf   = 1'b1;
    tbl[2].stall = 10;
    tbl[3].ovf   = 1'b1;
    tbl[4].ovf   = 1'b1;
    tbl[5].din[4] = 17'h1FFFF;
    tbl[5].din[5] = 17'h00001;
    tbl[5].dat[4] = 16'hFFFF;
    tbl[5].dat[5] = 16'h0002;

    repeat (3) @(negedge clk);
    chk(o_rdy === 1'b0, "rst_rdy", 64'(o_rdy), 64'd0);
    chk(o_val === 1'b0 && o_ovf === 1'b0, "rst_val_ovf",
        {62'b0, o_val, o_ovf}, 64'd0);
    chk_dat("rst_dat", o_dat, '0);
    i_rst_n = 1'b1;
    @(negedge clk);
    chk(o_rdy === 1'b1, "idle_rdy", 64'(o_rdy), 64'd1);

    for (int k = 0; k < 6; k++) begin
      xfer(tbl[k].din, tbl[k].stall, gdat, govf, lat);
      chk(lat == 13, $sformatf("lat_%0d", k), 64'(lat), 64'd13);
      chk_dat($sformatf("dat_%0d", k), gdat, tbl[k].dat);
      chk(govf === tbl[k].ovf, $sformatf("ovf_%0d", k),
          64'(govf), 64'(tbl[k].ovf));
    end

    // Reset in the middle of RESOLVE, then a mostly-zero operand.
    i_dat = tbl[2].din;
    i_val = 1'b1;
    @(negedge clk);
    i_val = 1'b0;
    repeat (6) @(negedge clk);
    #2 i_rst_n = 1'b0;
    #1;
    chk(o_val === 1'b0 && o_ovf === 1'b0 && o_rdy === 1'b0,
        "midrst_flags", {61'b0, o_val, o_ovf, o_rdy}, 64'd0);
    chk_dat("midrst_dat", o_dat, '0);
    @(negedge clk);
    i_rst_n = 1'b1;
    @(negedge clk);
    xfer(tbl[5].din, 0, gdat, govf, lat);
    chk(lat == 13, "lat_after_rst", 64'(lat), 64'd13);
    chk_dat("dat_after_rst", gdat, tbl[5].dat);
    chk(govf === 1'b0, "ovf_after_rst", 64'(govf), 64'd0);

    for (int t = 0; t < 1000; t++) begin
      for (int i = 0; i < NUM_WRDS; i++)
        d[i] = 17'($urandom_range(0, 17'h1FFFF));
      v = from_redun(d);
      xfer(d, $urandom_range(0, 3), gdat, govf, lat);
      chk_dat($sformatf("rnd_dat_%0d", t), gdat, v[1039:0]);
      chk(govf === (|v[1105:1040]), $sformatf("rnd_ovf_%0d", t),
          64'(govf), 64'(|v[1105:1040]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
